// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, counts retired instructions, flags bad opcodes.
module main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic             Zero,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_write;
    logic       pc_update;
    logic       branch;
  } ctrl_t;

  state_t cur, nxt;
  ctrl_t  ctrl;
  logic   legal;
  logic   retire;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.ir_write = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; c.pc_update = 1'b1; end
      S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
      S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    begin c.src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BEQ:      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
            (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_BEQ:       nxt = S_BEQ;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: nxt = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: nxt = S_ALUWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // Illegal opcodes leave Decode straight to Fetch and are not counted here.
  assign retire = (cur == S_MEMWB) || (cur == S_MEMWRITE) || (cur == S_ALUWB) || (cur == S_BEQ);

  // Outputs are registered from the next state so they always equal decode(cur).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= S_FETCH;
      ctrl    <= decode(S_FETCH);
      instret <= '0;
    end else begin
      cur  <= nxt;
      ctrl <= decode(nxt);
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign AdrSrc    = ctrl.adr_src;
  assign IRWrite   = ctrl.ir_write;
  assign ALUSrcA   = ctrl.src_a;
  assign ALUSrcB   = ctrl.src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ResultSrc = ctrl.result_src;
  assign RegWrite  = ctrl.reg_write;
  assign MemWrite  = ctrl.mem_write;
  assign PCWrite   = ctrl.pc_update | (ctrl.branch & Zero);
  assign illegal   = (cur == S_DECODE) & ~legal;
  assign state     = cur;

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle RISC-V main control state machine. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables cycle by cycle. It sits in the controller beside the ALU decoder and the immediate-source decoder. All three consume the same `op` field from the instruction register, and this block supplies the `ALUOp` and `IRWrite` those neighbours depend on. It also keeps a retired-instruction counter and flags unrecognised opcodes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `op`  input  7  opcode field of the instruction register (`instr[6:0]`).
- `Zero`  input  1  ALU zero flag.
- `AdrSrc`  output  1  memory address select: 0 = PC, 1 = ALUOut.
- `IRWrite`  output  1  instruction register and OldPC load enable.
- `ALUSrcA`  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- `ALUSrcB`  output  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- `ALUOp`  output  2  to the ALU decoder: 00 = add, 01 = subtract, 10 = funct-decoded.
- `ResultSrc`  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `RegWrite`  output  1  register file write enable.
- `MemWrite`  output  1  memory write enable.
- `PCWrite`  output  1  PC load enable, equal to `PCUpdate | (Branch & Zero)`.
- `illegal`  output  1  high during Decode when `op` is unrecognised.
- `state`  output  4  current state encoding, for debug.
- `instret`  output  CNT_W  count of retired instructions.

## Operation
- States and encodings:
  - Fetch = 0
  - Decode = 1
  - MemAdr = 2
  - MemRead = 3
  - MemWB = 4
  - MemWrite = 5
  - ExecuteR = 6
  - ExecuteI = 7
  - ALUWB = 8
  - BEQ = 9
  - JAL = 10
  - Encodings 11–15 are unused; the next state from any of them is Fetch.
- Transitions:
  - Fetch → Decode.
  - From Decode, by `op`:
    - 0000011 (lw) and 0100011 (sw) → MemAdr.
    - 0110011 (R-type) → ExecuteR.
    - 0010011 (I-type ALU) → ExecuteI.
    - 1100011 (beq) → BEQ.
    - 1101111 (jal) → JAL.
    - Any other value → Fetch.
  - From MemAdr: lw → MemRead; sw → MemWrite.
  - MemRead → MemWB.
  - ExecuteR, ExecuteI and JAL → ALUWB.
  - MemWB, MemWrite, ALUWB and BEQ → Fetch.
- Output values by state. This is a Moore machine: outputs decode from `state` only, except `PCWrite`. Every output not listed for a state is 0.
  - Fetch: `IRWrite`=1, `ALUSrcB`=10, `ResultSrc`=10, `PCUpdate`=1.
  - Decode: `ALUSrcA`=01, `ALUSrcB`=01 (computes the branch target).
  - MemAdr: `ALUSrcA`=10, `ALUSrcB`=01.
  - MemRead: `AdrSrc`=1.
  - MemWB: `ResultSrc`=01, `RegWrite`=1.
  - MemWrite: `AdrSrc`=1, `MemWrite`=1.
  - ExecuteR: `ALUSrcA`=10, `ALUOp`=10.
  - ExecuteI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10.
  - ALUWB: `RegWrite`=1.
  - BEQ: `ALUSrcA`=10, `ALUOp`=01, `Branch`=1.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `PCUpdate`=1.
- `PCUpdate` and `Branch` are internal signals. `PCWrite` is combinational on `Zero`, so it can be high only in Fetch, JAL, or BEQ with `Zero`=1.
- `illegal` is `(state == Decode) & op not in the list above`, combinational.
- `instret`:
  - Increments by 1 on each clock edge leaving MemWB, MemWrite, ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - Does not count an illegal opcode (Decode → Fetch).

## Timing
- Reset (`reset_n` low): `state` goes to Fetch immediately, independent of the clock, and `instret` goes to 0.
  - Outputs therefore show the Fetch values during reset: `IRWrite`=1, `PCWrite`=1, `ALUSrcB`=10, `ResultSrc`=10, all others 0, `illegal`=0.
  - The datapath is responsible for holding the PC in reset.
  - Asserting reset mid-instruction abandons the instruction: no further `RegWrite`/`MemWrite`, and no `instret` increment.
- Deassertion of `reset_n` is expected synchronous to `clk`. The first edge after release moves Fetch → Decode.
- Cycles per instruction:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - jal: 4
  - beq: 3
  - illegal: 2
- `op` is sampled only in Decode and MemAdr. It is stable there because `IRWrite` is 0 outside Fetch.
- `instret` is updated on the same edge that enters Fetch, and is visible during that Fetch cycle.

## Test plan
- Reset with `reset_n`=0 → `state`=0, `instret`=0, `IRWrite`=1, `PCWrite`=1. Release, then one edge → `state`=1, all enables 0.
- lw (`op`=0000011) → states 0,1,2,3,4,0. `AdrSrc`=1 in state 3. `RegWrite`=1 with `ResultSrc`=01 in state 4. `instret` 0→1 on entering Fetch.
- sw, then R-type (0110011), then I-type (0010011) back-to-back → sequences 0,1,2,5 / 0,1,6,8 / 0,1,7,8. `MemWrite`=1 only in state 5. `ALUOp`=10 in states 6 and 7. `instret`=3 at the end.
- beq (1100011) with `Zero`=1, then again with `Zero`=0 → `PCWrite`=1 in BEQ in the first case and 0 in the second. `ALUOp`=01 in both. Each takes 3 cycles.
- jal (1101111) → states 0,1,10,8. `PCWrite`=1 and `ALUSrcA`=01 in state 10. `RegWrite`=1 with `ResultSrc`=00 in state 8.
- Illegal `op`=1111111 → `illegal`=1 for exactly the Decode cycle, then Fetch, `instret` unchanged. Separately, assert `reset_n` low during MemRead → `state`=0 immediately, `instret`=0, and no `RegWrite` pulse follows.
